// File: rtl/axi2port_loopback_ctrl_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// axi2port_loopback_ctrl_if
// -----------------------------------------------------------------------------
// Purpose
//   Groups the streams and sideband signals between the loopback self-test
//   sequencer and the gdma<->port bridge.
//
// Signals
//   gdma2port_tvalid / _tready / _tdata : tx stream, sequencer -> bridge
//   port2gdma_tvalid / _tready / _tdata : rx stream, bridge -> sequencer
//   sim_packet_flag                     : bridge sim-packet mode request
//   sim_packet_length                   : expected sim-packet length in words
//   receve_packet_done                  : bridge sim-packet completion level
//
// Modports
//   master : sequencer side (drives tx valid/data, rx ready, sim-packet ctrl)
//   slave  : bridge side (the mirror image)
// -----------------------------------------------------------------------------
interface axi2port_loopback_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 5
);

  logic              gdma2port_tvalid;
  logic              gdma2port_tready;
  logic [DATA_W-1:0] gdma2port_tdata;

  logic              port2gdma_tvalid;
  logic              port2gdma_tready;
  logic [DATA_W-1:0] port2gdma_tdata;

  logic              sim_packet_flag;
  logic [LEN_W-1:0]  sim_packet_length;
  logic              receve_packet_done;

  modport master (
    output gdma2port_tvalid,
    input  gdma2port_tready,
    output gdma2port_tdata,
    input  port2gdma_tvalid,
    output port2gdma_tready,
    input  port2gdma_tdata,
    output sim_packet_flag,
    output sim_packet_length,
    input  receve_packet_done
  );

  modport slave (
    input  gdma2port_tvalid,
    output gdma2port_tready,
    input  gdma2port_tdata,
    output port2gdma_tvalid,
    input  port2gdma_tready,
    output port2gdma_tdata,
    input  sim_packet_flag,
    input  sim_packet_length,
    output receve_packet_done
  );

endinterface

// File: rtl/axi2port_loopback_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// axi2port_loopback_ctrl
// -----------------------------------------------------------------------------
// Purpose
//   Self-test sequencer for the gdma<->port bridge, clocked by gdma_clk.
//   One run streams cfg_len pattern words (seed, seed+1, ...) out on the tx
//   stream, then collects cfg_len words from the rx stream and compares each
//   one with the same pattern. Reports pass, a saturating error count and a
//   timeout flag when no handshake happens for TMO_CYC cycles.
//
// Ports
//   gdma_clk   in   single clock
//   rst        in   synchronous reset, active-high
//   start      in   1-cycle run request, ignored while a run is in progress
//   cfg_len    in   words per run, latched on an accepted start
//   cfg_seed   in   first pattern word, latched on an accepted start
//   busy       out  high from the accepted start up to (not incl.) done
//   done       out  1-cycle pulse at the end of a run
//   pass       out  run result, held until the next accepted start
//   timeout    out  run ended by timeout, held until the next accepted start
//   err_cnt    out  number of mismatching rx words, saturates at 255
//   bus        if   streams and sim-packet sideband (master modport)
//
// Configuration
//   SIM_PACKET_EN : when defined, the rx phase is replaced by a wait for the
//                   bridge's sim-packet completion (receve_packet_done).
//                   When undefined, sim_packet_flag/length are tied to 0 and
//                   receve_packet_done is unused.
// -----------------------------------------------------------------------------
module axi2port_loopback_ctrl #(
  parameter int unsigned      DATA_W  = 32,
  parameter int unsigned      LEN_W   = 5,
  parameter int unsigned      TMO_W   = 16,
  // All-ones is 16'hFFFF at the default width.
  parameter logic [TMO_W-1:0] TMO_CYC = '1
) (
  input  logic                       gdma_clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LEN_W-1:0]           cfg_len,
  input  logic [DATA_W-1:0]          cfg_seed,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       timeout,
  output logic [7:0]                 err_cnt,
  axi2port_loopback_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_RX,
    S_SIM_WAIT,
    S_DONE
  } state_e;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYC - TMO_W'(1);

  state_e             state_q;
  logic [LEN_W-1:0]   len_q;
  logic [DATA_W-1:0]  seed_q;
  logic [LEN_W-1:0]   tx_idx_q;
  logic [LEN_W-1:0]   rx_idx_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [7:0]         err_cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic               timeout_q;
  logic               tx_tvalid_q;
  logic [DATA_W-1:0]  tx_tdata_q;
  logic               rx_tready_q;
`ifdef SIM_PACKET_EN
  logic               sim_flag_q;
  // Counts the first SIM_WAIT cycles during which receve_packet_done may still
  // carry the level left over from a previous packet.
  logic [1:0]         sim_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // Handshake decode and rx compare
  // ---------------------------------------------------------------------------
  logic              tx_hs;
  logic              rx_hs;
  logic              tx_last;
  logic              rx_last;
  logic              tmo_hit;
  logic [DATA_W-1:0] rx_expect;
  logic              rx_mismatch;
  logic [7:0]        err_cnt_d;

  assign tx_hs   = tx_tvalid_q & bus.gdma2port_tready;
  assign rx_hs   = rx_tready_q & bus.port2gdma_tvalid;
  assign tx_last = (tx_idx_q == len_q - LEN_W'(1));
  assign rx_last = (rx_idx_q == len_q - LEN_W'(1));
  assign tmo_hit = (tmo_q == TMO_LAST);

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    rx_expect   = seed_q + DATA_W'(rx_idx_q);
    rx_mismatch = (bus.port2gdma_tdata != rx_expect);
    err_cnt_d   = err_cnt_q;
    if (rx_mismatch && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every register sees
  // the values from before the clock edge, regardless of statement order.
  always_ff @(posedge gdma_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      seed_q      <= '0;
      tx_idx_q    <= '0;
      rx_idx_q    <= '0;
      tmo_q       <= '0;
      err_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      tx_tvalid_q <= 1'b0;
      tx_tdata_q  <= '0;
      rx_tready_q <= 1'b0;
`ifdef SIM_PACKET_EN
      sim_flag_q  <= 1'b0;
      sim_cnt_q   <= '0;
`endif
    end else begin
      // done is a single-cycle pulse; only the transitions into DONE raise it.
      done_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q     <= cfg_len;
            seed_q    <= cfg_seed;
            tx_idx_q  <= '0;
            rx_idx_q  <= '0;
            tmo_q     <= '0;
            err_cnt_q <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            if (cfg_len == '0) begin
              // Empty run: nothing to send or check, report success at once.
              state_q <= S_DONE;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q     <= S_TX;
              busy_q      <= 1'b1;
              tx_tvalid_q <= 1'b1;
              tx_tdata_q  <= cfg_seed;
            end
          end
        end

        S_TX: begin
          if (tx_hs) begin
            tmo_q <= '0;
            if (tx_last) begin
              tx_tvalid_q <= 1'b0;
`ifdef SIM_PACKET_EN
              state_q     <= S_SIM_WAIT;
              sim_flag_q  <= 1'b1;
              sim_cnt_q   <= '0;
`else
              state_q     <= S_RX;
              rx_tready_q <= 1'b1;
`endif
            end else begin
              tx_idx_q   <= tx_idx_q + LEN_W'(1);
              tx_tdata_q <= seed_q + DATA_W'(tx_idx_q) + DATA_W'(1);
            end
          end else if (tmo_hit) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b1;
            pass_q      <= 1'b0;
            tx_tvalid_q <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        S_RX: begin
          if (rx_hs) begin
            tmo_q     <= '0;
            err_cnt_q <= err_cnt_d;
            if (rx_last) begin
              // Result uses err_cnt_d so the final word's compare is included.
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              rx_tready_q <= 1'b0;
              pass_q      <= (err_cnt_d == 8'd0);
            end else begin
              rx_idx_q <= rx_idx_q + LEN_W'(1);
            end
          end else if (tmo_hit) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b1;
            pass_q      <= 1'b0;
            rx_tready_q <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

`ifdef SIM_PACKET_EN
        S_SIM_WAIT: begin
          if ((sim_cnt_q == 2'd2) && bus.receve_packet_done) begin
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            sim_flag_q <= 1'b0;
            pass_q     <= (err_cnt_q == 8'd0);
          end else if (tmo_hit) begin
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b1;
            pass_q     <= 1'b0;
            sim_flag_q <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
            if (sim_cnt_q != 2'd2) begin
              sim_cnt_q <= sim_cnt_q + 2'd1;
            end
          end
        end
`endif

        S_DONE: begin
          // start is deliberately not looked at here.
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign timeout = timeout_q;
  assign err_cnt = err_cnt_q;

  assign bus.gdma2port_tvalid = tx_tvalid_q;
  assign bus.gdma2port_tdata  = tx_tdata_q;
  assign bus.port2gdma_tready = rx_tready_q;

`ifdef SIM_PACKET_EN
  assign bus.sim_packet_flag   = sim_flag_q;
  assign bus.sim_packet_length = len_q;
`else
  assign bus.sim_packet_flag   = 1'b0;
  assign bus.sim_packet_length = '0;

  logic unused_receve_packet_done;
  assign unused_receve_packet_done = bus.receve_packet_done;
`endif

endmodule

// File: tb/tb_axi2port_loopback_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_axi2port_loopback_ctrl
// -----------------------------------------------------------------------------
// Self-checking bench for axi2port_loopback_ctrl. The bench plays the bridge:
// it accepts tx words with a configurable ready pattern, echoes them back on
// the rx stream (optionally corrupting chosen words) and, with SIM_PACKET_EN,
// raises receve_packet_done after a chosen delay. Expected results come from
// the run rules: word i = seed + i, error count = number of corrupted words,
// pass = no errors and no timeout.
// -----------------------------------------------------------------------------
module tb_axi2port_loopback_ctrl;

  localparam int DATA_W  = 32;
  localparam int LEN_W   = 5;
  localparam int TMO_CYC = 65535;

  logic              gdma_clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  cfg_len;
  logic [DATA_W-1:0] cfg_seed;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [7:0]        err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  axi2port_loopback_ctrl_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  axi2port_loopback_ctrl #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .TMO_W  (16),
    .TMO_CYC(16'hFFFF)
  ) dut (
    .gdma_clk(gdma_clk),
    .rst     (rst),
    .start   (start),
    .cfg_len (cfg_len),
    .cfg_seed(cfg_seed),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .timeout (timeout),
    .err_cnt (err_cnt),
    .bus     (bus)
  );

  always #5 gdma_clk = ~gdma_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {12'd0, busy, done, pass, timeout, err_cnt,
            bus.gdma2port_tvalid, bus.port2gdma_tready, bus.sim_packet_flag,
            bus.sim_packet_length, bus.gdma2port_tdata};
  endfunction

  task automatic idle_inputs();
    start                  = 1'b0;
    bus.gdma2port_tready   = 1'b0;
    bus.port2gdma_tvalid   = 1'b0;
    bus.port2gdma_tdata    = '0;
    bus.receve_packet_done = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge gdma_clk);
    rst = 1'b0;
  endtask

  // tx_mode : 0 ready always, 1 ready toggles 1/0, 2 random ready
  // rx_mode : 0 echo as soon as possible, 1 random valid, 2 never valid
  // rpd_delay : SIM_WAIT cycle at which receve_packet_done rises (<0: never)
  task automatic run_case(input string tag, input logic [31:0] seed, input int len,
                          input int tx_mode, input int rx_mode, input logic [31:0] bad_mask,
                          input int rpd_delay, input bit noise, input bit abort_run,
                          input int budget);
    logic [31:0] tx_q[$];
    logic [31:0] prev_data;
    logic [31:0] rx_w;
    int  rx_n = 0, exp_err = 0, exp_rx = 0, last_tx = 0, done_at = -1, sw_n = 0;
    bit  stable_ok = 1'b1, flag_ok = 1'b1, prev_stall = 1'b0, aborted = 1'b0;
    bit  tx_ok, exp_to, exp_pass, t, v, no_done;

`ifdef SIM_PACKET_EN
    exp_to = (len != 0) && (rpd_delay < 0);
`else
    exp_to = (len != 0) && (rx_mode == 2);
    if (!exp_to) begin
      for (int i = 0; i < len; i++) if (bad_mask[i]) exp_err++;
      exp_rx = len;
    end
`endif
    exp_pass = !exp_to && (exp_err == 0);

    cfg_seed = seed;
    cfg_len  = LEN_W'(len);
    start    = 1'b1;
    @(negedge gdma_clk);
    start = 1'b0;
    check({tag, ":busy_after_start"}, busy, (len != 0));

    for (int cyc = 0; cyc < budget; cyc++) begin
      if (done) begin
        done_at = cyc;
        break;
      end
      if (abort_run && ((bus.port2gdma_tready && rx_n >= 1) || bus.sim_packet_flag)) begin
        aborted = 1'b1;
        break;
      end
      if (prev_stall && (!bus.gdma2port_tvalid || bus.gdma2port_tdata !== prev_data))
        stable_ok = 1'b0;

      case (tx_mode)
        0:       t = 1'b1;
        1:       t = (cyc % 2 == 0);
        default: t = 1'($urandom_range(0, 1));
      endcase
      bus.gdma2port_tready = t;
      if (bus.gdma2port_tvalid && t) begin
        tx_q.push_back(bus.gdma2port_tdata);
        last_tx    = cyc + 1;
        prev_stall = 1'b0;
      end else begin
        prev_stall = bus.gdma2port_tvalid;
      end
      prev_data = bus.gdma2port_tdata;

      v    = 1'b0;
      rx_w = '0;
      if (rx_n < tx_q.size()) begin
        case (rx_mode)
          0:       v = 1'b1;
          1:       v = 1'($urandom_range(0, 1));
          default: v = 1'b0;
        endcase
        rx_w = tx_q[rx_n];
        if (bad_mask[rx_n]) rx_w = (rx_w == 32'hDEAD_BEEF) ? 32'h0 : 32'hDEAD_BEEF;
      end
      bus.port2gdma_tvalid = v;
      bus.port2gdma_tdata  = rx_w;
      if (v && bus.port2gdma_tready) rx_n++;

`ifdef SIM_PACKET_EN
      if (bus.sim_packet_flag) begin
        if (bus.sim_packet_length !== LEN_W'(len)) flag_ok = 1'b0;
        bus.receve_packet_done = (rpd_delay >= 0) && (sw_n >= rpd_delay);
        sw_n++;
      end else begin
        bus.receve_packet_done = 1'b0;
      end
`else
      if (bus.sim_packet_flag !== 1'b0 || bus.sim_packet_length !== '0) flag_ok = 1'b0;
      bus.receve_packet_done = 1'($urandom_range(0, 1));
`endif

      if (noise) begin
        start    = ($urandom_range(0, 7) == 0);
        cfg_len  = LEN_W'($urandom);
        cfg_seed = $urandom;
      end
      @(negedge gdma_clk);
    end
    start = 1'b0;

    tx_ok = (tx_q.size() == len);
    foreach (tx_q[i]) if (tx_q[i] !== seed + 32'(i)) tx_ok = 1'b0;

    if (aborted) begin
      check({tag, ":tx_count"}, tx_q.size(), len);
      check({tag, ":tx_data"}, tx_ok, 1'b1);
      pulse_reset();
      check({tag, ":outs_after_rst"}, outs(), 64'd0);
      no_done = 1'b1;
      repeat (20) begin
        @(negedge gdma_clk);
        if (done || busy) no_done = 1'b0;
      end
      check({tag, ":no_done_after_rst"}, no_done, 1'b1);
      return;
    end

    check({tag, ":done_seen"}, (done_at >= 0), 1'b1);
    if (done_at < 0) begin
      pulse_reset();
      return;
    end

    check({tag, ":tx_count"}, tx_q.size(), len);
    check({tag, ":tx_data"}, tx_ok, 1'b1);
    if (tx_mode != 0) check({tag, ":tx_stable"}, stable_ok, 1'b1);
    check({tag, ":err_cnt"}, err_cnt, exp_err);
    check({tag, ":pass"}, pass, exp_pass);
    check({tag, ":timeout"}, timeout, exp_to);
    check({tag, ":busy_at_done"}, busy, 1'b0);
    check({tag, ":rx_count"}, rx_n, exp_rx);
    check({tag, ":sideband"}, flag_ok, 1'b1);
`ifdef SIM_PACKET_EN
    check({tag, ":flag_at_done"}, bus.sim_packet_flag, 1'b0);
    if (len != 0 && !exp_to)
      check({tag, ":sim_wait_cycles"}, sw_n, ((rpd_delay > 2) ? rpd_delay : 2) + 1);
`endif
    if (exp_to) check({tag, ":timeout_latency"}, done_at - last_tx, TMO_CYC);

    // A start during the DONE cycle must be ignored; results stay held.
    idle_inputs();
    cfg_len  = LEN_W'(5);
    cfg_seed = $urandom;
    start    = 1'b1;
    @(negedge gdma_clk);
    start = 1'b0;
    check({tag, ":after_done"}, {busy, done, pass, timeout, err_cnt},
          {1'b0, 1'b0, exp_pass, exp_to, 8'(exp_err)});
    @(negedge gdma_clk);
  endtask

  initial begin
    rst      = 1'b1;
    cfg_len  = '0;
    cfg_seed = '0;
    idle_inputs();
    repeat (3) @(negedge gdma_clk);
    check("reset_outputs", outs(), 64'd0);
    rst = 1'b0;
    @(negedge gdma_clk);
    check("idle_outputs", outs(), 64'd0);

    run_case("basic",    32'h0000_1000, 4, 0, 0, 32'h0, 2, 1'b0, 1'b0, 400);
    run_case("bad_word", 32'h0000_1000, 4, 0, 0, 32'h4, 2, 1'b0, 1'b0, 400);
    run_case("toggle",   $urandom,      3, 1, 0, 32'h0, 3, 1'b0, 1'b0, 400);
    run_case("len0",     $urandom,      0, 0, 0, 32'h0, 0, 1'b0, 1'b0, 400);
    run_case("rst_mid",  32'hFFFF_FFFF, 2, 0, 0, 32'h0, -1, 1'b0, 1'b1, 400);
    run_case("sim_len5", 32'h0000_0055, 5, 2, 1, 32'h0, 4, 1'b0, 1'b0, 400);
    run_case("max_len",  32'hFFFF_FFF0, 31, 0, 0, 32'h8000_0001, 0, 1'b0, 1'b0, 400);

    for (int i = 0; i < 16; i++) begin
      run_case($sformatf("rnd%0d", i), $urandom, $urandom_range(1, 31),
               $urandom_range(1, 2), $urandom_range(0, 1), $urandom & $urandom,
               $urandom_range(0, 6), 1'b1, 1'b0, 2000);
    end

    run_case("rx_timeout", 32'hA5A5_0000, 2, 0, 2, 32'h0, -1, 1'b0, 1'b0, 70000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
